// File: rtl/ram_burst_ctrl.sv
// Burst front-end for a single-port RAM with 1-cycle read latency and a 2-deep read FIFO.
// Optional: RAM_BURST_CTRL_WRAP_EN wraps bursts modulo depth instead of truncating at the top.
module ram_burst_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [ADDR_WIDTH-1:0] req_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);
  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                         state;
  logic [ADDR_WIDTH-1:0]          addr;
  logic [ADDR_WIDTH:0]            iss_left;
  logic                           inflight, inflight_last;
  logic [1:0]                     cnt;
  logic                           wptr, rptr;
  logic [1:0][DATA_WIDTH-1:0]     fdata;
  logic [1:0]                     flast;
  logic [ADDR_WIDTH:0]            beats, lenp1;
  logic [2:0]                     occ;
  logic                           pop, credit, last_iss, rd_issue, wr_beat;

  assign lenp1 = {1'b0, req_len} + 1'b1;
`ifdef RAM_BURST_CTRL_WRAP_EN
  assign beats = lenp1;
`else
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  logic [ADDR_WIDTH:0] room;
  assign room  = DEPTH - {1'b0, req_addr};
  assign beats = (lenp1 > room) ? room : lenp1;
`endif

  // A beat popped this cycle frees its slot, so 1 beat/cycle is sustained under rd_ready
  assign pop      = rd_valid && rd_ready;
  assign occ      = {1'b0, cnt} + {2'b0, inflight};
  assign credit   = (occ - {2'b0, pop}) < 3'd2;
  assign last_iss = (iss_left == ONE);
  assign rd_issue = !rst && (state == READ) && (iss_left != '0) && credit;
  assign wr_beat  = !rst && (state == WRITE) && wr_valid;

  assign req_ready = (state == IDLE);
  assign wr_ready  = !rst && (state == WRITE);
  assign ram_en    = rd_issue || wr_beat;
  assign ram_we    = wr_beat;
  assign ram_addr  = addr;
  assign ram_din   = wr_data;
  assign rd_valid  = (cnt != 2'd0);
  assign rd_data   = fdata[rptr];
  assign rd_last   = rd_valid && flast[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      addr          <= '0;
      iss_left      <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      cnt           <= 2'd0;
      wptr          <= 1'b0;
      rptr          <= 1'b0;
      fdata         <= '0;
      flast         <= '0;
    end else begin
      inflight      <= rd_issue;
      inflight_last <= rd_issue && last_iss;
      if (inflight) begin
        fdata[wptr] <= ram_dout;
        flast[wptr] <= inflight_last;
        wptr        <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      cnt <= cnt + {1'b0, inflight} - {1'b0, pop};
      if (rd_issue || wr_beat) begin
        addr     <= addr + 1'b1;
        iss_left <= iss_left - 1'b1;
      end
      case (state)
        IDLE:
          if (req_valid) begin
            addr     <= req_addr;
            iss_left <= beats;
            state    <= req_we ? WRITE : READ;
          end
        WRITE:
          if (wr_beat && last_iss) state <= IDLE;
        READ:
          if (pop && rd_last) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Scoreboard bench for ram_burst_ctrl with a behavioural 1-cycle-latency RAM behind it.
module tb_ram_burst_ctrl;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  logic req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr, req_len;
  logic wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic rd_valid, rd_ready, rd_last;
  logic [DW-1:0] rd_data;
  logic ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;

  ram_burst_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] shadow [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = '0;
      shadow[i] = '0;
    end
    ram_dout = '0;
  end
  always @(posedge clk)
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      else        ram_dout      <= mem[ram_addr];
    end

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wexp_t;
  typedef struct { logic [DW-1:0] d; logic l; } rexp_t;
  wexp_t         wq[$];
  logic [AW-1:0] raq[$];
  rexp_t         rq[$];

  int n_chk = 0;
  int n_err = 0;
  int outst = 0;
  bit stall_prev = 0;
  logic [DW-1:0] held_d;
  logic held_l;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic int nb(input int a, input int l);
`ifdef RAM_BURST_CTRL_WRAP_EN
    return l + 1;
`else
    return (a + l > DEPTH - 1) ? DEPTH - a : l + 1;
`endif
  endfunction

  // RAM-side and read-stream monitors
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 0;
    end else begin
      if (ram_en && ram_we) begin
        chk("wr_q", wq.size() > 0, 1);
        if (wq.size() > 0) begin
          wexp_t e;
          e = wq.pop_front();
          chk("wr_addr", ram_addr, e.a);
          chk("wr_data", ram_din, e.d);
        end
      end
      if (ram_en && !ram_we) begin
        chk("ra_q", raq.size() > 0, 1);
        if (raq.size() > 0) chk("rd_addr", ram_addr, raq.pop_front());
      end
      if (stall_prev) begin
        chk("hold_v", rd_valid, 1);
        chk("hold_d", rd_data, held_d);
        chk("hold_l", rd_last, held_l);
      end
      if (rd_valid && rd_ready) begin
        chk("rd_q", rq.size() > 0, 1);
        if (rq.size() > 0) begin
          rexp_t e;
          e = rq.pop_front();
          chk("rd_data", rd_data, e.d);
          chk("rd_last", rd_last, e.l);
        end
      end
      outst += (ram_en && !ram_we) ? 1 : 0;
      outst -= (rd_valid && rd_ready) ? 1 : 0;
      chk("outst_le2", outst <= 2, 1);
      stall_prev = rd_valid && !rd_ready;
      held_d = rd_data;
      held_l = rd_last;
    end
  end

  task automatic do_write(input int a, input int l, input logic [DW-1:0] base);
    int n;
    n = nb(a, l);
    for (int i = 0; i < n; i++) begin
      wexp_t e;
      e.a = AW'(a + i);
      e.d = base + DW'(i);
      wq.push_back(e);
      shadow[(a + i) % DEPTH] = e.d;
    end
    req_valid = 1; req_we = 1; req_addr = AW'(a); req_len = AW'(l);
    @(negedge clk);
    chk("wr_req_rdy", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 0; req_we = 0;
    for (int i = 0; i < n; i++) begin
      wr_valid = 1;
      wr_data = base + DW'(i);
      @(negedge clk);
      chk("wr_rdy", wr_ready, 1);
      @(posedge clk); #1;
    end
    wr_valid = 0;
    @(negedge clk);
    chk("wr_done_rdy", req_ready, 1);
    chk("wr_done_wrdy", wr_ready, 0);
    chk("wr_done_en", ram_en, 0);
    @(posedge clk); #1;
  endtask

  task automatic push_rd(input int a, input int l);
    int n;
    n = nb(a, l);
    for (int i = 0; i < n; i++) begin
      rexp_t e;
      raq.push_back(AW'(a + i));
      e.d = shadow[(a + i) % DEPTH];
      e.l = (i == n - 1);
      rq.push_back(e);
    end
  endtask

  task automatic do_read(input int a, input int l, input bit tog);
    int n, k, npop, first_k, last_k;
    n = nb(a, l);
    push_rd(a, l);
    req_valid = 1; req_we = 0; req_addr = AW'(a); req_len = AW'(l);
    @(posedge clk); #1;
    req_valid = 0;
    npop = 0; first_k = -1; last_k = -1; k = 0;
    while (npop < n && k < 100) begin
      rd_ready = tog ? (k % 2 == 0) : 1'b1;
      @(negedge clk);
      if (k == 1) chk("rd_early", rd_valid, 0);
      if (rd_valid && rd_ready) begin
        if (first_k < 0) first_k = k;
        last_k = k;
        npop++;
      end
      @(posedge clk); #1;
      k++;
    end
    chk("rd_beats", npop, n);
    chk("rd_lat", first_k, 2);
    if (!tog) chk("rd_tput", last_k - first_k + 1, n);
    rd_ready = 0;
    @(negedge clk);
    chk("rd_done_rdy", req_ready, 1);
    chk("rd_extra", rd_valid, 0);
    chk("rd_done_en", ram_en, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1; req_valid = 0; req_we = 0; req_addr = '0; req_len = '0;
    wr_valid = 0; wr_data = '0; rd_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdv", rd_valid, 0);
    chk("rst_last", rd_last, 0);
    chk("rst_en", ram_en, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_data", rd_data, 0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("idle_req_rdy", req_ready, 1);
    chk("idle_wr_rdy", wr_ready, 0);
    @(posedge clk); #1;

    do_write(2, 3, 8'hA1);
    do_read(2, 3, 0);
    do_read(2, 3, 1);
    do_write(0, 7, 8'h30);
    do_read(0, 7, 1);
    do_read(0, 7, 0);
    do_write(6, 3, 8'hC1);
    do_read(6, 3, 0);
    do_write(7, 0, 8'hEE);
    do_read(7, 0, 0);
    do_write(0, 0, 8'h55);
    do_read(0, 0, 0);

    // reset while the second beat of a 4-beat read is being presented
    push_rd(2, 3);
    req_valid = 1; req_we = 0; req_addr = 3'd2; req_len = 3'd3;
    @(posedge clk); #1;
    req_valid = 0; rd_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1;
    @(negedge clk);
    chk("mid_rst_en", ram_en, 0);
    @(posedge clk); #1;
    rst = 0; rd_ready = 0;
    raq.delete(); rq.delete(); outst = 0;
    @(negedge clk);
    chk("post_rst_rdv", rd_valid, 0);
    chk("post_rst_en", ram_en, 0);
    chk("post_rst_rdy", req_ready, 1);
    chk("post_rst_data", rd_data, 0);
    @(posedge clk); #1;
    do_read(2, 3, 0);
    do_read(6, 3, 1);

    chk("wq_left", wq.size(), 0);
    chk("raq_left", raq.size(), 0);
    chk("rq_left", rq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end
endmodule
